// File: rtl/clock_pkg.sv
// Shared constants and BCD helpers for the time-of-day counter.
// Latency: none (constants and a pure combinational function).
// Backpressure: none.
package clock_pkg;

    // Last legal value of each field; reaching it means the next step wraps to 00.
    localparam logic [7:0] SEC_MAX  = 8'h59;
    localparam logic [7:0] MIN_MAX  = 8'h59;
    localparam logic [7:0] HOUR_MAX = 8'h23;

    // Step a two-digit BCD value by one, wrapping to 00 after 'max'.
    // The caller detects the carry-out itself by comparing the input to 'max'.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        logic [7:0] r;
        if (v == max) begin
            r = 8'h00;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer plus debouncer for one active-low push button.
// Latency: press pulses DEB_CNT+2 cycles after the raw key first reads low.
// Backpressure: none; the pulse is one cycle and is not held.
//
// Ports: clk, rst (sync, active-high), key (raw, active-low, async),
//        press (one-cycle pulse on each accepted press).
module key_debounce #(
    parameter int DEB_CNT = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic press
);

    localparam int CW = $clog2(DEB_CNT + 1);

    logic          sync_a;
    logic          sync_b;
    logic          level;
    logic [CW-1:0] cnt;

    // The counter measures how long the synchronized input has disagreed with
    // the accepted level; any agreement (a bounce back) restarts the count.
    // Release is debounced the same way, so a new press needs a stable high first.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a <= 1'b1;
            sync_b <= 1'b1;
            level  <= 1'b1;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync_a <= key;
            sync_b <= sync_a;
            press  <= 1'b0;
            if (sync_b == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_CNT - 1)) begin
                level <= sync_b;
                cnt   <= '0;
                press <= ~sync_b;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/time_counter.sv
// 24-hour BCD clock with a 1 s prescaler and debounced hour/minute set keys.
// Latency: fields change one cycle after tick_1s, or one cycle after a debounced press.
// Backpressure: none; ticks and key events are applied the cycle they occur.
//
// Ports: clk, rst (sync, active-high), key_h/key_m (raw active-low buttons),
//        hour_bcd/min_bcd/sec_bcd (BCD time), tick_1s (one-cycle per second).
// Optional: define ALARM_EN to add alarm_h/alarm_m inputs and the alarm output.
module time_counter
    import clock_pkg::*;
#(
    parameter int CNT_1S  = 50_000_000,
    parameter int DEB_CNT = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_h,
    input  logic       key_m,
    output logic [7:0] hour_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       tick_1s
`ifdef ALARM_EN
    ,
    input  logic [7:0] alarm_h,
    input  logic [7:0] alarm_m,
    output logic       alarm
`endif
);

    localparam int PW = (CNT_1S > 1) ? $clog2(CNT_1S) : 1;

    logic [PW-1:0] presc;
    logic [PW-1:0] presc_nx;
    logic [7:0]    sec_nx;
    logic [7:0]    min_nx;
    logic [7:0]    hour_nx;
    logic          ev_h;
    logic          ev_m;
    logic          hour_step;

    key_debounce #(.DEB_CNT(DEB_CNT)) u_deb_h (
        .clk   (clk),
        .rst   (rst),
        .key   (key_h),
        .press (ev_h)
    );

    key_debounce #(.DEB_CNT(DEB_CNT)) u_deb_m (
        .clk   (clk),
        .rst   (rst),
        .key   (key_m),
        .press (ev_m)
    );

    assign tick_1s = (presc == PW'(CNT_1S - 1));

    // A minute-set press restarts the second from zero, so it overrides a
    // coincident tick entirely. The hour step is an OR of the key and the
    // roll-over carry, so both together still advance the hour only once.
    always_comb begin
        presc_nx  = presc + PW'(1);
        sec_nx    = sec_bcd;
        min_nx    = min_bcd;
        hour_nx   = hour_bcd;
        hour_step = ev_h;
        if (ev_m) begin
            presc_nx = '0;
            sec_nx   = 8'h00;
            min_nx   = bcd_inc(min_bcd, MIN_MAX);
        end else if (tick_1s) begin
            presc_nx = '0;
            sec_nx   = bcd_inc(sec_bcd, SEC_MAX);
            if (sec_bcd == SEC_MAX) begin
                min_nx = bcd_inc(min_bcd, MIN_MAX);
                if (min_bcd == MIN_MAX) begin
                    hour_step = 1'b1;
                end
            end
        end
        if (hour_step) begin
            hour_nx = bcd_inc(hour_bcd, HOUR_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc    <= '0;
            sec_bcd  <= 8'h00;
            min_bcd  <= 8'h00;
            hour_bcd <= 8'h00;
        end else begin
            presc    <= presc_nx;
            sec_bcd  <= sec_nx;
            min_bcd  <= min_nx;
            hour_bcd <= hour_nx;
        end
    end

`ifdef ALARM_EN
    // Compare against the next time value so alarm moves in the same cycle
    // as the displayed hour/minute rather than one cycle behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            alarm <= 1'b0;
        end else begin
            alarm <= (hour_nx == alarm_h) && (min_nx == alarm_m);
        end
    end
`endif

endmodule

// File: doc/time_counter.md
TIME_COUNTER -- requirements
Module: time_counter

Interface
REQ-001 SHALL have parameter CNT_1S, default 50_000_000, meaning clk cycles per second (bench overrides it to 50).
REQ-002 SHALL have parameter DEB_CNT, default 1_000_000, meaning the key stable-time in clk cycles (20 ms at 50 MHz; bench overrides it to 10).
REQ-003 SHALL have port clk, input, 1 bit: single system clock; every register is clocked on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port key_h, input, 1 bit: raw hour-set button, active-low, asynchronous to clk.
REQ-006 SHALL have port key_m, input, 1 bit: raw minute-set button, active-low, asynchronous to clk.
REQ-007 SHALL have port hour_bcd, output, 8 bits: hours in BCD, range 00-23.
REQ-008 SHALL have port min_bcd, output, 8 bits: minutes in BCD, range 00-59.
REQ-009 SHALL have port sec_bcd, output, 8 bits: seconds in BCD, range 00-59.
REQ-010 SHALL have port tick_1s, output, 1 bit: one-cycle pulse each time the seconds field advances.

Function
REQ-011 SHALL run a prescaler counting 0..CNT_1S-1 and wrapping to 0; tick_1s SHALL be high in exactly the cycle in which the prescaler equals CNT_1S-1.
REQ-012 SHALL update the BCD time registers on the clock edge that ends the tick_1s cycle, so they change one cycle after the tick asserts.
REQ-013 SHALL increment seconds on each tick: units digit 9 wraps to 0 with a carry into tens; seconds 59 wraps to 00 with a carry into minutes.
REQ-014 SHALL increment minutes on a seconds carry, wrapping 59 to 00 with a carry into hours.
REQ-015 SHALL increment hours on a minutes carry: units digit 9 wraps to 0 with a carry into tens; hours 23 wraps to 00.
REQ-016 SHALL never produce a BCD digit above 9 or a field value outside its stated range.
REQ-017 SHALL pass each key through a 2-flop synchronizer followed by a debouncer; a press is accepted when the synchronized level has been low for DEB_CNT consecutive cycles.
REQ-018 SHALL generate exactly one one-cycle internal event per accepted press, on the high-to-low debounced edge.
REQ-019 SHALL NOT generate another event for the same key until the key has been high for DEB_CNT consecutive cycles (release debounce).
REQ-020 SHALL, on a key_m event: advance minutes by one (59 wraps to 00, no carry into hours), clear seconds to 00 and clear the prescaler to 0.
REQ-021 SHALL, on a key_h event: advance hours by one (23 wraps to 00); minutes, seconds and the prescaler are unchanged.
REQ-022 SHALL, when a key_m event and a tick coincide, apply the key_m result and discard the tick (no seconds or carry update).
REQ-023 SHALL, when a key_h event and a tick-generated carry into hours coincide, advance hours by exactly one.
REQ-024 SHALL, when key_h and key_m events occur in the same cycle, apply both.
REQ-025 SHALL reset the debounce counter of a key to 0 whenever that key's level bounces before reaching DEB_CNT.

Reset
REQ-026 SHALL, while rst=1 at a clock edge, load hour_bcd=8'h00, min_bcd=8'h00, sec_bcd=8'h00, tick_1s=0, prescaler=0, debounce counters=0, debounced levels=1 and synchronizer flops=1.
REQ-027 SHALL discard any press in progress when reset is applied mid-press; a key held through reset release SHALL be accepted only after DEB_CNT further cycles low.

Configuration
REQ-028 SHALL, with ALARM_EN defined, add inputs alarm_h[7:0] and alarm_m[7:0] (BCD) and an output alarm.
REQ-029 SHALL, with ALARM_EN defined, register alarm high while hour_bcd==alarm_h and min_bcd==alarm_m, and low otherwise; alarm is 0 in reset.
REQ-030 SHALL, without ALARM_EN, omit the alarm ports and the compare logic entirely.

Structure
REQ-031 SHALL place BCD limit constants (SEC_MAX 8'h59, MIN_MAX 8'h59, HOUR_MAX 8'h23) and the BCD-increment function in the shared package clock_pkg.
REQ-032 SHALL implement the synchronizer and debouncer as one sub-module, key_debounce, instantiated once per key with parameter DEB_CNT and output a one-cycle press pulse.

Verification
REQ-033 SHALL check: CNT_1S=50, release reset -> first tick_1s 50 cycles after reset release, sec_bcd=8'h01 on the following cycle, one tick every 50 cycles thereafter.
REQ-034 SHALL check: preload 23:59:59 through key presses and ticks, then one tick -> 00:00:00 with no illegal intermediate value.
REQ-035 SHALL check: key_m low with 3-cycle bounces, then held 20 cycles (DEB_CNT=10) -> exactly one minute increment, sec_bcd=8'h00, prescaler restarted.
REQ-036 SHALL check: key_h event forced in the same cycle as a 22:59:59 tick -> hour_bcd=8'h23, min_bcd=8'h00, sec_bcd=8'h00.
REQ-037 SHALL check: rst asserted for 1 cycle at 12:34:56 while key_m is held -> all fields 00 and no minute event until 10 cycles low after reset release.
REQ-038 SHALL check: with ALARM_EN, alarm set to 00:01 -> alarm rises when min_bcd becomes 8'h01 and falls when it becomes 8'h02.
